// File: rtl/subtractor_serial_ctrl.sv
// subtractor_serial_ctrl: bit-serial a - b, one borrow-chained bit-slice per clock, LSB first, with start/busy/done handshake
module subtractor_serial_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, diff_q, diff_d;
    logic br_q, br_d, borrow_out_q, borrow_out_d, busy_q, busy_d, done_q, done_d;
    logic a_i, b_i, d_i, br_nxt;
    always_comb begin
        a_i = a_q[cnt_q];
        b_i = b_q[cnt_q];
        d_i = a_i ^ b_i ^ br_q;
        br_nxt = (~a_i & b_i) | (~(a_i ^ b_i) & br_q);
        state_d = state_q;
        cnt_d = cnt_q;
        a_d = a_q;
        b_d = b_q;
        br_d = br_q;
        diff_d = diff_q;
        borrow_out_d = borrow_out_q;
        case (state_q)
            IDLE: if (start) begin
                a_d = a;
                b_d = b;
                cnt_d = '0;
                br_d = 1'b0;
                diff_d = '0;
                state_d = RUN;
            end
            RUN: begin
                diff_d[cnt_q] = d_i;
                br_d = br_nxt;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    borrow_out_d = br_nxt;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == RUN;
        done_d = state_d == DONE;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            a_q <= '0;
            b_q <= '0;
            br_q <= 1'b0;
            diff_q <= '0;
            borrow_out_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            a_q <= a_d;
            b_q <= b_d;
            br_q <= br_d;
            diff_q <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end
    assign busy = busy_q;
    assign done = done_q;
    assign diff = diff_q;
    assign borrow_out = borrow_out_q;
endmodule
